// File: rtl/uart_pkg.sv
// Shared UART receive types: parity encodings, receiver FSM states, RX FIFO entry layout.
// Entries carry the widest supported character; narrower builds leave the upper data bits zero.
package uart_pkg;

  localparam int unsigned MAX_DATA_BITS = 9;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HI
  } rx_state_e;

  typedef struct packed {
    logic [MAX_DATA_BITS-1:0] data;
    logic                     perr;
    logic                     ferr;
  } rx_entry_t;

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic synchronous FIFO: head visible combinationally while !empty, write lands next cycle.
// A push into a full FIFO is taken only when a pop happens in the same cycle; otherwise ignored.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == LW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign pop_dat = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: nothing reads a slot before it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver feeding a valid/ready FIFO; m_valid rises 1 cycle after the stop sample.
// No backpressure on the line: a character arriving at a full, stalled FIFO is dropped and flags overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVS        = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_parity_err,
  output logic                 m_frame_err,
  output logic                 overflow,
  input  logic                 overflow_clr,
  output logic                 break_det,
  output logic [LVL_W-1:0]     level
);

  localparam int unsigned    SW        = $clog2(OVS);
  localparam int unsigned    BW        = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0]  HALF_LAST = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0]  FULL_LAST = SW'(OVS - 1);

  logic                 sync1_q, rs_q, rs_prev_q;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d, div_load;
  logic                 tick, mid_bit;
  rx_state_e            state_q, state_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [BW-1:0]        bidx_q, bidx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 par_bit_q, par_bit_d;
  logic                 push, is_break;
  rx_entry_t            push_entry, head, out_entry;
  rx_entry_t            hold_q, hold_d;
  logic                 fifo_full, fifo_empty, pop;
  logic                 overflow_q, overflow_d;
  logic                 break_det_q, break_det_d;
  logic                 out_unused;

  // Two-flop synchroniser plus one history flop for start-edge detection; idle line is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      rs_q      <= 1'b1;
      rs_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rxd;
      rs_q      <= sync1_q;
      rs_prev_q <= rs_q;
    end
  end

  always_comb begin
    div_load  = (baud_div == '0) ? '0 : baud_div - 1'b1;
    tick      = (div_cnt_q == '0);
    div_cnt_d = tick ? div_load : div_cnt_q - 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    bidx_d    = bidx_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    par_bit_d = par_bit_q;
    push      = 1'b0;
    is_break  = 1'b0;
    mid_bit   = tick && (scnt_q == FULL_LAST);
    if (tick) scnt_d = scnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (rs_prev_q && !rs_q) begin
          state_d = START;
          scnt_d  = '0;
        end
      end
      START: begin
        if (tick && (scnt_q == HALF_LAST)) begin
          scnt_d = '0;
          if (rs_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bidx_d    = '0;
            perr_d    = 1'b0;
            par_bit_d = 1'b0;
          end
        end
      end
      DATA: begin
        if (mid_bit) begin
          shreg_d = {rs_q, shreg_q[DATA_BITS-1:1]};
          bidx_d  = bidx_q + 1'b1;
          if (bidx_q == BW'(DATA_BITS - 1))
            state_d = parity_enabled(parity_mode) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (mid_bit) begin
          par_bit_d = rs_q;
          perr_d    = rs_q != ((^shreg_q) ^ (parity_mode == PAR_ODD));
          state_d   = STOP;
        end
      end
      STOP: begin
        if (mid_bit) begin
          push     = 1'b1;
          // par_bit_q stays 0 when parity is off, so it only gates breaks on parity frames.
          is_break = (shreg_q == '0) && !rs_q && !par_bit_q;
          state_d  = rs_q ? IDLE : WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (rs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign push_entry = '{data: MAX_DATA_BITS'(shreg_q), perr: perr_q, ferr: ~rs_q};
  assign pop        = m_valid && m_ready;

  uart_sync_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  // Full implies m_valid, so a stalled consumer is exactly the drop condition.
  always_comb begin
    overflow_d  = (push && fifo_full && !m_ready) || (overflow_q && !overflow_clr);
    break_det_d = is_break;
    hold_d      = pop ? head : hold_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q   <= '0;
      state_q     <= IDLE;
      scnt_q      <= '0;
      bidx_q      <= '0;
      shreg_q     <= '0;
      perr_q      <= 1'b0;
      par_bit_q   <= 1'b0;
      overflow_q  <= 1'b0;
      break_det_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      bidx_q      <= bidx_d;
      shreg_q     <= shreg_d;
      perr_q      <= perr_d;
      par_bit_q   <= par_bit_d;
      overflow_q  <= overflow_d;
      break_det_q <= break_det_d;
      hold_q      <= hold_d;
    end
  end

  // When empty, the last popped entry stays on the outputs.
  assign out_entry    = fifo_empty ? hold_q : head;
  assign m_valid      = !fifo_empty;
  assign m_data       = out_entry.data[DATA_BITS-1:0];
  assign m_parity_err = out_entry.perr;
  assign m_frame_err  = out_entry.ferr;
  assign overflow     = overflow_q;
  assign break_det    = break_det_q;
  assign out_unused   = ^out_entry.data;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized frames on rxd, checked against a queue model of the character stream.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int OVS   = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rxd = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic [1:0]  parity_mode = 2'd0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic        m_parity_err, m_frame_err, overflow;
  logic        overflow_clr = 1'b0;
  logic        break_det;
  logic [2:0]  level;

  uart_rx_fifo #(.DATA_BITS(8), .OVS(OVS), .FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .baud_div(baud_div), .parity_mode(parity_mode),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_parity_err(m_parity_err),
    .m_frame_err(m_frame_err), .overflow(overflow), .overflow_clr(overflow_clr),
    .break_det(break_det), .level(level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int brk_seen = 0;
  int vld_rise = -1;
  logic vld_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (break_det) brk_seen <= brk_seen + 1;
    if (m_valid && !vld_prev) vld_rise <= cyc;
    vld_prev <= m_valid;
  end

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  bit   model_ovf = 1'b0;
  int   exp_brk = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_start = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int bit_time();
    return ((baud_div == 16'd0) ? 1 : int'(baud_div)) * OVS;
  endfunction

  // What a correct receiver must report for one frame.
  task automatic expect_char(input logic [7:0] d, input logic [1:0] mode, input bit pbit, input bit stop);
    exp_t e;
    bit pen;
    pen    = (mode == 2'd1) || (mode == 2'd2);
    e.data = d;
    e.ferr = !stop;
    e.perr = pen && (pbit != ((^d) ^ (mode == 2'd2)));
    if (d == 8'h00 && !stop && (!pen || !pbit)) exp_brk++;
    if (exp_q.size() >= DEPTH) model_ovf = 1'b1;
    else exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit, input bit stop,
                            input int low_extra);
    int b;
    b = bit_time();
    while (cyc % 4 != 0) @(negedge clk);
    last_start = cyc;
    rxd = 1'b0;
    hold(b);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      hold(b);
    end
    if (pen) begin
      rxd = pbit;
      hold(b);
    end
    rxd = stop;
    hold(b * (1 + (stop ? 0 : low_extra)));
    rxd = 1'b1;
    hold(2 * b);
  endtask

  task automatic send_char(input logic [7:0] d, input logic [1:0] mode, input bit pbit,
                           input bit stop, input int low_extra);
    parity_mode = mode;
    send_frame(d, (mode == 2'd1) || (mode == 2'd2), pbit, stop, low_extra);
    expect_char(d, mode, pbit, stop);
  endtask

  task automatic drain_all();
    exp_t e;
    int t;
    logic [7:0] last_d;
    bit any;
    any = 1'b0;
    last_d = 8'h00;
    while (exp_q.size() > 0) begin
      t = 0;
      while (!m_valid && t < 4000) begin
        @(negedge clk);
        t++;
      end
      e = exp_q.pop_front();
      check("head_valid", m_valid, 1);
      check("head_data", m_data, e.data);
      check("head_perr", m_parity_err, e.perr);
      check("head_ferr", m_frame_err, e.ferr);
      last_d = e.data;
      any = 1'b1;
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
    end
    check("drained_valid", m_valid, 0);
    if (any) check("empty_hold_data", m_data, last_d);
  endtask

  task automatic check_reset_outputs();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_perr", m_parity_err, 0);
    check("rst_ferr", m_frame_err, 0);
    check("rst_overflow", overflow, 0);
    check("rst_break", break_det, 0);
    check("rst_level", level, 0);
  endtask

  initial begin
    int d_rise;
    int s2;
    int b;
    logic [7:0] rd;
    logic [7:0] r5a;
    logic [1:0] rmode;
    bit rpbit, rstop;

    hold(3);
    check_reset_outputs();
    reset = 1'b0;
    hold(3);

    // 8N1 decode and first-character latency
    send_char(8'h55, 2'd0, 1'b0, 1'b1, 0);
    d_rise = vld_rise - last_start;
    check("valid_latency_window", (d_rise >= 600 && d_rise <= 620), 1);
    send_char(8'hA3, 2'd0, 1'b0, 1'b1, 0);
    check("level_two", level, 2);
    drain_all();

    // Parity even/odd with both parity bit values
    send_char(8'h07, 2'd1, 1'b1, 1'b1, 0);
    send_char(8'h07, 2'd1, 1'b0, 1'b1, 0);
    send_char(8'h07, 2'd2, 1'b1, 1'b1, 0);
    send_char(8'h07, 2'd2, 1'b0, 1'b1, 0);
    check("level_parity", level, exp_q.size());
    drain_all();

    // Framing error with the line held low afterwards, then a 12-bit break
    send_char(8'h41, 2'd0, 1'b0, 1'b0, 3);
    check("level_frame", level, 1);
    drain_all();
    send_char(8'h00, 2'd0, 1'b0, 1'b0, 2);
    check("break_pulses", brk_seen, exp_brk);
    check("level_break", level, 1);
    drain_all();

    // Glitch shorter than half a bit
    rxd = 1'b0;
    hold(20);
    rxd = 1'b1;
    hold(2 * bit_time());
    check("glitch_level", level, 0);
    check("glitch_valid", m_valid, 0);
    send_char(8'h3C, 2'd0, 1'b0, 1'b1, 0);
    drain_all();

    // Randomized frames
    for (int i = 0; i < 8; i++) begin
      rd    = 8'($urandom);
      rmode = 2'($urandom_range(0, 3));
      rpbit = 1'($urandom_range(0, 1));
      rstop = ($urandom_range(0, 3) != 0);
      if (i == 5) begin
        rd = 8'h00;
        rstop = 1'b0;
      end
      send_char(rd, rmode, rpbit, rstop, rstop ? 0 : 1);
      if (i % 2 == 1) drain_all();
    end
    check("random_break_pulses", brk_seen, exp_brk);
    parity_mode = 2'd0;

    // Overflow with a stalled consumer
    for (int v = 1; v <= 5; v++) send_char(8'(v), 2'd0, 1'b0, 1'b1, 0);
    check("ovf_level", level, 4);
    check("ovf_set", overflow, model_ovf);
    drain_all();
    check("ovf_sticky", overflow, model_ovf);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    model_ovf = 1'b0;
    check("ovf_cleared", overflow, model_ovf);

    // Full FIFO: pop lands in the same cycle as the push
    for (int v = 0; v < 4; v++) send_char(8'h11 + 8'(v), 2'd0, 1'b0, 1'b1, 0);
    check("full_level", level, 4);
    while (cyc % 4 != 0) @(negedge clk);
    s2 = cyc;
    fork
      send_frame(8'h15, 1'b0, 1'b0, 1'b1, 0);
      begin
        while (cyc < s2 + d_rise - 1) @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
      end
    join
    void'(exp_q.pop_front());
    expect_char(8'h15, 2'd0, 1'b0, 1'b1);
    check("coincide_no_ovf", overflow, model_ovf);
    check("coincide_level", level, 4);
    drain_all();

    // Reset during bit 3 of 0x5A, with one entry already queued
    send_char(8'h77, 2'd0, 1'b0, 1'b1, 0);
    b = bit_time();
    r5a = 8'h5A;
    rxd = 1'b0;
    hold(b);
    for (int i = 0; i < 3; i++) begin
      rxd = r5a[i];
      hold(b);
    end
    rxd = r5a[3];
    hold(b / 2);
    reset = 1'b1;
    hold(2);
    check_reset_outputs();
    rxd = 1'b1;
    reset = 1'b0;
    hold(1);
    check_reset_outputs();
    exp_q.delete();
    hold(10 * b);
    check("rst_no_push", level, 0);
    send_char(8'h33, 2'd0, 1'b0, 1'b1, 0);
    drain_all();

    // baud_div of 0 runs at one tick per clock
    baud_div = 16'd0;
    hold(8);
    send_char(8'($urandom), 2'd1, 1'($urandom_range(0, 1)), 1'b1, 0);
    send_char(8'hC9, 2'd0, 1'b0, 1'b1, 0);
    drain_all();
    check("final_break_pulses", brk_seen, exp_brk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
